// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, registered Q/R/flags.
// state | meaning
// IDLE  | waiting for start, results held
// CALC  | one restoring iteration per edge, N edges total
// DONE  | results valid, done pulses for this single cycle
module seq_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N:0]     rem_q, rem_d;
    logic [N-1:0]   dvd_q, dvd_d;
    logic [N-1:0]   div_q, div_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [N-1:0]   res_r_q, res_r_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           div_zero_q, div_zero_d;

    logic [N:0]     shifted;
    logic [N+1:0]   trial;
    logic           qbit;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        quo_d      = quo_q;
        res_r_d    = res_r_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        // Dividend register doubles as the quotient shift register.
        shifted = {rem_q[N-1:0], dvd_q[N-1]};
        trial   = {1'b0, shifted} + {1'b0, ~{1'b0, div_q}} + (N+2)'(1);
        qbit    = trial[N+1];

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d      = A;
                    div_d      = B;
                    rem_d      = '0;
                    cnt_d      = '0;
                    div_zero_d = 1'b0;
                    if (B == '0) begin
                        state_d    = DONE;
                        div_zero_d = 1'b1;
                        quo_d      = '1;
                        res_r_d    = A;
                        done_d     = 1'b1;
                    end else begin
                        state_d = CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
            CALC: begin
                rem_d = qbit ? trial[N:0] : shifted;
                dvd_d = N'({dvd_q, qbit});
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quo_d   = dvd_d;
                    res_r_d = rem_d[N-1:0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            dvd_q      <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            quo_q      <= '0;
            res_r_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            quo_q      <= quo_d;
            res_r_q    <= res_r_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign Q        = quo_q;
    assign R        = res_r_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule
